thread_scheduler: RTL and testbench
===================================

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 Parameters SHALL be:
- NUM_THREADS, default 4, number of hardware threads.
- NUM_ALUS, default 2, number of shared execution ALUs.
- TID_W, default 3, width of a thread index.
REQ-002 Clock and reset ports SHALL be: clk input 1 (single clock, rising-edge); rst input 1 (asynchronous, active-low reset).
REQ-003 Remaining ports SHALL be:
- en input 1: scheduler enable.
- thr_ready input NUM_THREADS: thread t has a decoded instruction ready to issue.
- thr_flush input NUM_THREADS: jump/hold flush of thread t.
- thr_done input NUM_THREADS: thread t's issued instruction retired.
- alu_busy input NUM_ALUS: ALU a cannot accept an issue this cycle.
- grant_valid output NUM_ALUS: ALU a receives an issue.
- grant_tid output NUM_ALUS x TID_W: thread index issued to ALU a.
- inflight output NUM_THREADS: thread t has an unretired issue.
- rr_ptr output TID_W: current round-robin start thread.
- state output 2: FSM state (IDLE=0, RUN=1, DRAIN=2).

Function
REQ-004 FSM transitions SHALL be:
- IDLE->RUN when en=1.
- RUN->DRAIN when en=0.
- DRAIN->RUN when en=1.
- DRAIN->IDLE when en=0 and inflight==0.
- State 3 is illegal and SHALL be forced to IDLE on the next edge.
REQ-005 Grants SHALL be issued only in RUN; in IDLE and DRAIN, grant_valid SHALL be 0 on the next edge.
REQ-006 A thread SHALL be eligible in a cycle iff thr_ready=1, thr_flush=0, thr_done=0 and inflight=0, all sampled that cycle.
REQ-007 Eligible threads SHALL be scanned in order rr_ptr, rr_ptr+1, ... modulo NUM_THREADS.
REQ-008 The k-th eligible thread SHALL be assigned to the k-th non-busy ALU in ascending ALU index; any surplus of threads or ALUs SHALL receive no grant.
REQ-009 A thread SHALL never be granted to more than one ALU in the same cycle.
REQ-010 grant_valid and grant_tid SHALL be registered, appearing one cycle after the sampled inputs; grant_tid SHALL hold its previous value when grant_valid=0.
REQ-011 On a grant of thread t, inflight[t] SHALL set on the same edge as grant_valid.
REQ-012 inflight[t] SHALL clear on the edge after thr_done[t]=1 or thr_flush[t]=1.
REQ-013 If a set and a clear of inflight[t] coincide, the clear SHALL win; REQ-006 excludes the grant in that case.
REQ-014 rr_ptr SHALL update to (highest-ordered granted thread in scan order + 1) mod NUM_THREADS; it SHALL be unchanged when no grant occurs.
REQ-015 rr_ptr arithmetic SHALL wrap from NUM_THREADS-1 to 0 and SHALL never hold a value >= NUM_THREADS.
REQ-016 When all ALUs are busy, no grant SHALL occur and rr_ptr SHALL be unchanged.
REQ-017 thr_done or thr_flush on a thread with inflight=0 SHALL be ignored without error.
REQ-018 In DRAIN, inflight bits SHALL continue to clear per REQ-012.

Reset
REQ-019 While rst=0, immediately and independent of clk:
- state = IDLE
- grant_valid = 0
- grant_tid = 0
- inflight = 0
- rr_ptr = 0
REQ-020 Reset asserted mid-operation SHALL discard all inflight tracking; after release, the first grant SHALL occur no earlier than one cycle after entering RUN.

Verification
REQ-021 Release reset, en=1, thr_ready=4'b1111, alu_busy=0 -> first grants ALU0=tid0, ALU1=tid1; rr_ptr=2; inflight=4'b0011.
REQ-022 Continuing REQ-021, pulse thr_done=4'b0011 one cycle -> next grants are tid2 and tid3; rr_ptr wraps to 0; tid0 and tid1 are not regranted in the done cycle.
REQ-023 thr_ready=4'b0100, alu_busy=2'b01 -> ALU1 gets tid2, ALU0 grant_valid=0; with alu_busy=2'b11, no grants and rr_ptr unchanged.
REQ-024 tid1 in flight, thr_flush[1]=1 and thr_ready[1]=1 in the same cycle -> inflight[1]=0 next cycle, no grant of tid1 that cycle, tid1 granted the cycle after.
REQ-025 With inflight=4'b1001, drop en -> state=DRAIN, no grants; after thr_done clears both bits -> state=IDLE.
REQ-026 Assert rst=0 between clock edges with inflight nonzero -> all outputs are at reset values before the next edge.

Source files
------------

// File: rtl/thread_scheduler.sv
// Round-robin issue scheduler: picks eligible threads starting at rr_ptr and
// hands them out to non-busy ALUs in ascending ALU order, tracks which threads
// have an unretired issue, and gates issue with an IDLE/RUN/DRAIN FSM.
module thread_scheduler #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_ALUS    = 2,
  parameter int TID_W       = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_THREADS-1:0]    thr_ready,
  input  logic [NUM_THREADS-1:0]    thr_flush,
  input  logic [NUM_THREADS-1:0]    thr_done,
  input  logic [NUM_ALUS-1:0]       alu_busy,
  output logic [NUM_ALUS-1:0]       grant_valid,
  output logic [NUM_ALUS*TID_W-1:0] grant_tid,
  output logic [NUM_THREADS-1:0]    inflight,
  output logic [TID_W-1:0]          rr_ptr,
  output logic [1:0]                state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [TID_W:0] NT = (TID_W+1)'(NUM_THREADS);

  logic [1:0]               state_nxt;
  logic                     run;
  logic [NUM_THREADS-1:0]   elig;
  logic [NUM_ALUS-1:0]      g_valid;
  logic [NUM_ALUS*TID_W-1:0] g_tid;
  logic [NUM_THREADS-1:0]   set_mask;
  logic [TID_W-1:0]         rr_nxt;
  logic [NUM_ALUS-1:0]      used;
  logic                     took;
  logic [TID_W:0]           sum;
  logic [TID_W:0]           nxt_sum;
  logic [TID_W-1:0]         idx;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state; the unused encoding falls back to IDLE
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = en ? RUN : IDLE;
      RUN:     state_nxt = en ? RUN : DRAIN;
      DRAIN:   state_nxt = en ? RUN : ((inflight == '0) ? IDLE : DRAIN);
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: issue is only allowed while running
  always_comb begin
    run = (state == RUN);
  end

  // A thread may issue only if ready and not retiring, flushing or already in flight
  always_comb begin
    elig = thr_ready & ~thr_flush & ~thr_done & ~inflight;
  end

  // Scan threads from rr_ptr; each eligible thread takes the lowest free, non-busy ALU
  always_comb begin
    g_valid  = '0;
    g_tid    = grant_tid;
    set_mask = '0;
    rr_nxt   = rr_ptr;
    used     = '0;
    took     = 1'b0;
    sum      = '0;
    nxt_sum  = '0;
    idx      = '0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      sum = {1'b0, rr_ptr} + (TID_W+1)'(k);
      if (sum >= NT) sum = sum - NT;
      idx  = sum[TID_W-1:0];
      took = 1'b0;
      if (elig[idx]) begin
        for (int a = 0; a < NUM_ALUS; a++) begin
          if (!took && !alu_busy[a] && !used[a]) begin
            took                    = 1'b1;
            used[a]                 = 1'b1;
            g_valid[a]              = 1'b1;
            g_tid[a*TID_W +: TID_W] = idx;
            set_mask[idx]           = 1'b1;
            // later scan positions overwrite, so this ends as last granted + 1
            nxt_sum = {1'b0, idx} + 1'b1;
            if (nxt_sum >= NT) nxt_sum = nxt_sum - NT;
            rr_nxt = nxt_sum[TID_W-1:0];
          end
        end
      end
    end
  end

  // Registered grants, in-flight tracking (clear beats set) and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_valid <= '0;
      grant_tid   <= '0;
      inflight    <= '0;
      rr_ptr      <= '0;
    end else begin
      grant_valid <= run ? g_valid : '0;
      if (run) begin
        grant_tid <= g_tid;
        rr_ptr    <= rr_nxt;
      end
      inflight <= (inflight | (run ? set_mask : '0)) & ~(thr_done | thr_flush);
    end
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler: hand-computed expectations per step.
module tb_thread_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] thr_ready, thr_flush, thr_done;
  logic [1:0] alu_busy;
  logic [1:0] grant_valid;
  logic [5:0] grant_tid;
  logic [3:0] inflight;
  logic [2:0] rr_ptr;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  thread_scheduler #(.NUM_THREADS(4), .NUM_ALUS(2), .TID_W(3)) dut (
    .clk(clk), .rst(rst), .en(en),
    .thr_ready(thr_ready), .thr_flush(thr_flush), .thr_done(thr_done),
    .alu_busy(alu_busy), .grant_valid(grant_valid), .grant_tid(grant_tid),
    .inflight(inflight), .rr_ptr(rr_ptr), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // advance one edge and settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [1:0] gv,
                         input logic [2:0] t0, input logic [2:0] t1,
                         input logic [3:0] inf, input logic [2:0] rr);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".gv"},    32'(grant_valid), 32'(gv));
    chk({tag, ".tid0"},  32'(grant_tid[2:0]), 32'(t0));
    chk({tag, ".tid1"},  32'(grant_tid[5:3]), 32'(t1));
    chk({tag, ".inf"},   32'(inflight), 32'(inf));
    chk({tag, ".rr"},    32'(rr_ptr), 32'(rr));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0;
    thr_ready = '0; thr_flush = '0; thr_done = '0; alu_busy = '0;
    #12;
    chk_all("reset", 2'd0, 2'b00, 3'd0, 3'd0, 4'b0000, 3'd0);
    rst = 1'b1;

    // first grants: IDLE->RUN, then tid0/tid1 issued
    en = 1'b1; thr_ready = 4'b1111;
    tick();
    chk_all("enter_run", 2'd1, 2'b00, 3'd0, 3'd0, 4'b0000, 3'd0);
    tick();
    chk_all("first_grant", 2'd1, 2'b11, 3'd0, 3'd1, 4'b0011, 3'd2);

    // done on tid0/1: tid2/3 issued, pointer wraps, tid0/1 not re-granted
    thr_done = 4'b0011;
    tick();
    chk_all("done_wrap", 2'd1, 2'b11, 3'd2, 3'd3, 4'b1100, 3'd0);

    // nothing ready, everything retires: grant_tid holds
    thr_ready = 4'b0000; thr_done = 4'b1111;
    tick();
    chk_all("hold_tid", 2'd1, 2'b00, 3'd2, 3'd3, 4'b0000, 3'd0);

    // ALU0 busy: tid2 goes to ALU1
    thr_done = '0; thr_ready = 4'b0100; alu_busy = 2'b01;
    tick();
    chk_all("alu0_busy", 2'd1, 2'b10, 3'd2, 3'd2, 4'b0100, 3'd3);

    // all ALUs busy: no grant, pointer unchanged
    thr_ready = 4'b1011; alu_busy = 2'b11;
    tick();
    chk_all("all_busy", 2'd1, 2'b00, 3'd2, 3'd2, 4'b0100, 3'd3);

    // tid1 issued from pointer 3 (scan 3,0,1)
    thr_ready = 4'b0010; alu_busy = 2'b00;
    tick();
    chk_all("tid1_issue", 2'd1, 2'b01, 3'd1, 3'd2, 4'b0110, 3'd2);

    // flush tid1 while still ready: cleared, not granted this cycle
    thr_flush = 4'b0010;
    tick();
    chk_all("flush", 2'd1, 2'b00, 3'd1, 3'd2, 4'b0100, 3'd2);

    // tid1 granted on the following cycle
    thr_flush = '0;
    tick();
    chk_all("after_flush", 2'd1, 2'b01, 3'd1, 3'd2, 4'b0110, 3'd2);

    // retire 1/2, issue 3 and 0 in scan order 2,3,0,1
    thr_done = 4'b0110; thr_ready = 4'b1001;
    tick();
    chk_all("scan_order", 2'd1, 2'b11, 3'd3, 3'd0, 4'b1001, 3'd1);

    // drop enable: DRAIN, no grants
    thr_done = '0; thr_ready = '0; en = 1'b0;
    tick();
    chk_all("drain", 2'd2, 2'b00, 3'd3, 3'd0, 4'b1001, 3'd1);

    // ready threads still get nothing in DRAIN
    thr_ready = 4'b1111;
    tick();
    chk_all("drain_nogrant", 2'd2, 2'b00, 3'd3, 3'd0, 4'b1001, 3'd1);

    // retirements continue to clear in DRAIN
    thr_done = 4'b1001;
    tick();
    chk_all("drain_clear", 2'd2, 2'b00, 3'd3, 3'd0, 4'b0000, 3'd1);

    thr_done = '0;
    tick();
    chk_all("to_idle", 2'd0, 2'b00, 3'd3, 3'd0, 4'b0000, 3'd1);

    // rebuild in-flight state, then async reset between edges
    en = 1'b1;
    tick();
    chk_all("rerun", 2'd1, 2'b00, 3'd3, 3'd0, 4'b0000, 3'd1);
    tick();
    chk_all("rerun_grant", 2'd1, 2'b11, 3'd1, 3'd2, 4'b0110, 3'd3);
    #2 rst = 1'b0;
    #1;
    chk_all("async_rst", 2'd0, 2'b00, 3'd0, 3'd0, 4'b0000, 3'd0);
    #3 rst = 1'b1;

    // after release: one cycle to enter RUN before any grant
    tick();
    chk_all("post_rst_run", 2'd1, 2'b00, 3'd0, 3'd0, 4'b0000, 3'd0);
    tick();
    chk_all("post_rst_grant", 2'd1, 2'b11, 3'd0, 3'd1, 4'b0011, 3'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
